// File: rtl/onchip_memory_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port on-chip RAM.
// One transaction in flight at a time; RAM read data is valid the cycle after issue.
module onchip_memory_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata,
    output logic                  protocol_err
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;   // 1'b1 selects m1
    logic              last_q, last_d;     // requester served by the last accepted command
    logic              perr_q, perr_d;
    logic              clken_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic              req0_s, req1_s;
    logic              g_rd_s, g_wr_s, issue_s;
    logic              rdv0_s, rdv1_s;
    logic [ADDR_W-1:0] g_addr_s;
    logic [BE_W-1:0]   g_be_s;
    logic [DATA_W-1:0] g_wdata_s;

    assign req0_s    = m0_read | m0_write;
    assign req1_s    = m1_read | m1_write;
    assign g_rd_s    = grant_q ? m1_read       : m0_read;
    assign g_wr_s    = grant_q ? m1_write      : m0_write;
    assign g_addr_s  = grant_q ? m1_address    : m0_address;
    assign g_be_s    = grant_q ? m1_byteenable : m0_byteenable;
    assign g_wdata_s = grant_q ? m1_writedata  : m0_writedata;
    // A grant whose strobes vanished before acceptance is dropped without touching memory
    assign issue_s   = (state_q == ISSUE) && (g_rd_s || g_wr_s);
    assign rdv0_s    = (state_q == RDATA) && !grant_q;
    assign rdv1_s    = (state_q == RDATA) && grant_q;

    // Next-state, arbitration and hold-register update logic
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        perr_d   = perr_q | (m0_read & m0_write) | (m1_read & m1_write);
        case (state_q)
            IDLE: begin
                if (req0_s && req1_s) begin
                    state_d = ISSUE;
                    grant_d = ~last_q;
                end else if (req0_s || req1_s) begin
                    state_d = ISSUE;
                    grant_d = req1_s;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (issue_s) begin
                    last_d  = grant_q;
                    addr_d  = g_addr_s;
                    be_d    = g_be_s;
                    wdata_d = g_wdata_s;
                    if (g_wr_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RDATA;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RDATA: begin
                state_d = IDLE;
                if (grant_q) begin
                    rdata1_d = mem_readdata;
                end else begin
                    rdata0_d = mem_readdata;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and hold registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            perr_q   <= 1'b0;
            clken_q  <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            perr_q   <= perr_d;
            clken_q  <= 1'b1;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign mem_chipselect   = issue_s;
    assign mem_write        = issue_s & g_wr_s;
    assign mem_address      = issue_s ? g_addr_s  : addr_q;
    assign mem_byteenable   = issue_s ? g_be_s    : be_q;
    assign mem_writedata    = issue_s ? g_wdata_s : wdata_q;
    assign mem_clken        = clken_q;

    assign m0_waitrequest   = !(issue_s && !grant_q);
    assign m1_waitrequest   = !(issue_s && grant_q);
    assign m0_readdatavalid = rdv0_s;
    assign m1_readdatavalid = rdv1_s;
    assign m0_readdata      = rdv0_s ? mem_readdata : rdata0_q;
    assign m1_readdata      = rdv1_s ? mem_readdata : rdata1_q;

    assign protocol_err     = perr_q;
endmodule
